// File: rtl/osc_seq_pkg.sv
// Shared state encoding and sizing helpers for the oscillator-clocked reset sequencer.
package osc_seq_pkg;

   typedef enum logic [2:0] {
      STARTUP,
      PLL_RST,
      WAIT_LOCK,
      RELEASE,
      RUN,
      FAIL
   } seq_state_t;

   localparam int RETRY_CNT_W = 8;

   // Width of a counter able to reach the largest of the timing parameters.
   function automatic int cnt_width(input int a, input int b, input int c,
                                    input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, both stages cleared by the asynchronous reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/osc_reset_sequencer.sv
// Oscillator-clocked power-up sequencer: settle, PLL reset, lock qualification, staggered release.
// Define OSC_RST_SEQ_RETRY_LIMIT_EN to park in FAIL once retries exceed MAX_RETRIES.
module osc_reset_sequencer
   import osc_seq_pkg::*;
#(
   parameter int STARTUP_CYCLES      = 1024,
   parameter int PLL_RST_CYCLES      = 32,
   parameter int LOCK_STABLE_CYCLES  = 256,
   parameter int LOCK_TIMEOUT_CYCLES = 65535,
   parameter int NUM_STAGES          = 3,
   parameter int STAGE_GAP_CYCLES    = 16,
   parameter int MAX_RETRIES         = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_lock,
   input  logic                   sw_reset_req,
   output logic                   pll_reset,
   output logic [NUM_STAGES-1:0]  stage_rst_n,
   output logic                   ready,
   output logic                   lock_lost,
   output logic [RETRY_CNT_W-1:0] retry_cnt,
   output logic                   seq_fail
);

   localparam int CNT_W = cnt_width(STARTUP_CYCLES, PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                    LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES);

   if (NUM_STAGES < 1 || NUM_STAGES > 8 || MAX_RETRIES < 0 || MAX_RETRIES > 254) begin : g_bad_cfg
      $error("osc_reset_sequencer: unsupported parameter set");
   end

   seq_state_t             state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [CNT_W-1:0]       stable_cnt, stable_nxt;
   logic                   pll_reset_nxt, ready_nxt, lock_lost_nxt;
   logic [NUM_STAGES-1:0]  stage_nxt;
   logic [RETRY_CNT_W-1:0] retry_cnt_nxt, retry_inc;
   logic                   lock_s, restart, retry_evt;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_CNT_W'(1);

`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
   logic seq_fail_q, seq_fail_nxt, go_fail;
   assign seq_fail = seq_fail_q;
`else
   assign seq_fail = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= STARTUP;
         cnt         <= '0;
         stable_cnt  <= '0;
         pll_reset   <= 1'b1;
         stage_rst_n <= '0;
         ready       <= 1'b0;
         lock_lost   <= 1'b0;
         retry_cnt   <= '0;
`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
         seq_fail_q  <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         stable_cnt  <= stable_nxt;
         pll_reset   <= pll_reset_nxt;
         stage_rst_n <= stage_nxt;
         ready       <= ready_nxt;
         lock_lost   <= lock_lost_nxt;
         retry_cnt   <= retry_cnt_nxt;
`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
         seq_fail_q  <= seq_fail_nxt;
`endif
      end
   end

   // Per-state timing first; software request and retry handling then override it,
   // so any path back to PLL_RST shares one set of output values.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      stable_nxt    = '0;
      pll_reset_nxt = pll_reset;
      stage_nxt     = stage_rst_n;
      ready_nxt     = ready;
      lock_lost_nxt = lock_lost;
      retry_cnt_nxt = retry_cnt;
      restart       = 1'b0;
      retry_evt     = 1'b0;
`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
      seq_fail_nxt  = seq_fail_q;
      go_fail       = 1'b0;
`endif

      case (state)
         STARTUP: begin
            if (cnt == CNT_W'(STARTUP_CYCLES - 1)) restart = 1'b1;
            else                                   cnt_nxt = cnt + CNT_W'(1);
         end
         PLL_RST: begin
            if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
               state_nxt     = WAIT_LOCK;
               cnt_nxt       = '0;
               pll_reset_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            stable_nxt = lock_s ? stable_cnt + CNT_W'(1) : '0;
            if (lock_s && stable_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
               state_nxt  = RELEASE;
               cnt_nxt    = '0;
               stable_nxt = '0;
               stage_nxt  = NUM_STAGES'(1);
            end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
               retry_evt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               retry_evt = 1'b1;
            end else if (stage_rst_n[NUM_STAGES-1]) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
               ready_nxt = 1'b1;
            end else if (cnt == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
               stage_nxt = (stage_rst_n << 1) | NUM_STAGES'(1);
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               retry_evt     = 1'b1;
               lock_lost_nxt = 1'b1;
            end
         end
         FAIL: begin
         end
         default: restart = 1'b1;
      endcase

      if (sw_reset_req && state != STARTUP) begin
         restart       = 1'b1;
         retry_evt     = 1'b0;
         lock_lost_nxt = lock_lost;
`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
         if (state == FAIL) begin
            retry_cnt_nxt = '0;
            seq_fail_nxt  = 1'b0;
         end
`endif
      end

      if (retry_evt) begin
         restart       = 1'b1;
         retry_cnt_nxt = retry_inc;
`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
         go_fail       = retry_inc > RETRY_CNT_W'(MAX_RETRIES);
`endif
      end

      if (restart) begin
         state_nxt     = PLL_RST;
         cnt_nxt       = '0;
         stable_nxt    = '0;
         pll_reset_nxt = 1'b1;
         stage_nxt     = '0;
         ready_nxt     = 1'b0;
      end

`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
      if (go_fail) begin
         state_nxt    = FAIL;
         seq_fail_nxt = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Directed scoreboard bench for osc_reset_sequencer with shortened timing parameters.
`timescale 1ns/1ps
module tb_osc_reset_sequencer;

   localparam int NS = 3;
`ifdef OSC_RST_SEQ_RETRY_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pll_lock;
   logic          sw_reset_req;
   logic          pll_reset;
   logic [NS-1:0] stage_rst_n;
   logic          ready;
   logic          lock_lost;
   logic [7:0]    retry_cnt;
   logic          seq_fail;

   typedef struct {
      int            at;
      string         tag;
      logic          pll_reset;
      logic [NS-1:0] stages;
      logic          ready;
      logic          lock_lost;
      logic [7:0]    retry;
      logic          seq_fail;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   osc_reset_sequencer #(
      .STARTUP_CYCLES      (8),
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (4),
      .LOCK_TIMEOUT_CYCLES (20),
      .NUM_STAGES          (NS),
      .STAGE_GAP_CYCLES    (2),
      .MAX_RETRIES         (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_lock     (pll_lock),
      .sw_reset_req (sw_reset_req),
      .pll_reset    (pll_reset),
      .stage_rst_n  (stage_rst_n),
      .ready        (ready),
      .lock_lost    (lock_lost),
      .retry_cnt    (retry_cnt),
      .seq_fail     (seq_fail)
   );

   task automatic applyStimulus(input logic lock, input logic sw);
      pll_lock     = lock;
      sw_reset_req = sw;
   endtask

   task automatic expectAt(input int at, input string tag, input logic pr, input logic [NS-1:0] st,
                           input logic rd, input logic ll, input logic [7:0] rc, input logic sf);
      exp_t e;
      e.at = at; e.tag = tag; e.pll_reset = pr; e.stages = st;
      e.ready = rd; e.lock_lost = ll; e.retry = rc; e.seq_fail = sf;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("[TB] FAIL %s.%s observed %0h expected %0h", tag, field, obs, expv);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp(e.tag, "pll_reset",   8'(pll_reset),   8'(e.pll_reset));
      cmp(e.tag, "stage_rst_n", 8'(stage_rst_n), 8'(e.stages));
      cmp(e.tag, "ready",       8'(ready),       8'(e.ready));
      cmp(e.tag, "lock_lost",   8'(lock_lost),   8'(e.lock_lost));
      cmp(e.tag, "retry_cnt",   retry_cnt,       e.retry);
      cmp(e.tag, "seq_fail",    8'(seq_fail),    8'(e.seq_fail));
   endtask

   task automatic checkNow();
      while (sb.size() > 0 && sb[0].at <= cyc) checkOutput(sb.pop_front());
   endtask

   task automatic runTo(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
         checkNow();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      cyc = 0;
      expectAt(0, "reset", 1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
      checkNow();

      // Bring-up with lock arriving three cycles into WAIT_LOCK.
      rst_n = 1'b1;
      expectAt(11, "startup_hold", 1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(12, "pll_release",  1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
      runTo(15);
      applyStimulus(1'b1, 1'b0);
      expectAt(20, "pre_release", 1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(21, "stage0",      1'b0, 3'b001, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(22, "stage0_hold", 1'b0, 3'b001, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(23, "stage1",      1'b0, 3'b011, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(24, "stage1_hold", 1'b0, 3'b011, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(25, "stage2",      1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(26, "run",         1'b0, 3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
      runTo(30);

      // Lock drop in RUN.
      applyStimulus(1'b0, 1'b0);
      expectAt(32, "run_before_drop", 1'b0, 3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
      expectAt(33, "lock_drop",       1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(36, "pll_rst_hold",    1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(37, "wait_lock2",      1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      runTo(38);

      // Relock with a two-cycle glitch during the stable count.
      applyStimulus(1'b1, 1'b0);
      runTo(40);
      applyStimulus(1'b0, 1'b0);
      runTo(42);
      applyStimulus(1'b1, 1'b0);
      expectAt(44, "glitch_no_release", 1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(47, "glitch_waiting",    1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(48, "glitch_release",    1'b0, 3'b001, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(53, "relock_run",        1'b0, 3'b111, 1'b1, 1'b1, 8'd1, 1'b0);
      runTo(55);

      // Software reset in RUN, then coincident with lock qualification.
      applyStimulus(1'b1, 1'b1);
      runTo(56);
      applyStimulus(1'b1, 1'b0);
      expectAt(56, "sw_reset_run", 1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(60, "sw_wait_lock", 1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      runTo(63);
      applyStimulus(1'b1, 1'b1);
      runTo(64);
      applyStimulus(1'b1, 1'b0);
      expectAt(64, "sw_beats_qual", 1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(68, "wait_lock3",    1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(72, "release3",      1'b0, 3'b001, 1'b0, 1'b1, 8'd1, 1'b0);
      runTo(72);

      // Lock loss during RELEASE, then repeated timeouts.
      applyStimulus(1'b0, 1'b0);
      expectAt(74,  "release3_stage1", 1'b0, 3'b011, 1'b0, 1'b1, 8'd1, 1'b0);
      expectAt(75,  "release_abort",   1'b1, 3'b000, 1'b0, 1'b1, 8'd2, 1'b0);
      expectAt(79,  "wait_timeout1",   1'b0, 3'b000, 1'b0, 1'b1, 8'd2, 1'b0);
      expectAt(98,  "before_timeout",  1'b0, 3'b000, 1'b0, 1'b1, 8'd2, 1'b0);
      expectAt(99,  "timeout1",        1'b1, 3'b000, 1'b0, 1'b1, 8'd3, LIMIT);
      expectAt(102, "pll_rst_retry",   1'b1, 3'b000, 1'b0, 1'b1, 8'd3, LIMIT);
      expectAt(103, "wait_timeout2",   LIMIT, 3'b000, 1'b0, 1'b1, 8'd3, LIMIT);
      expectAt(123, "timeout2",        1'b1, 3'b000, 1'b0, 1'b1, LIMIT ? 8'd3 : 8'd4, LIMIT);
      runTo(125);

      applyStimulus(1'b0, 1'b1);
      runTo(126);
      applyStimulus(1'b0, 1'b0);
      expectAt(126, "sw_restart",      1'b1, 3'b000, 1'b0, 1'b1, LIMIT ? 8'd0 : 8'd4, 1'b0);
      expectAt(129, "sw_restart_hold", 1'b1, 3'b000, 1'b0, 1'b1, LIMIT ? 8'd0 : 8'd4, 1'b0);
      expectAt(130, "sw_restart_wait", 1'b0, 3'b000, 1'b0, 1'b1, LIMIT ? 8'd0 : 8'd4, 1'b0);
      runTo(130);

      // Asynchronous reset in the middle of RELEASE.
      applyStimulus(1'b1, 1'b0);
      expectAt(136, "release4",        1'b0, 3'b001, 1'b0, 1'b1, LIMIT ? 8'd0 : 8'd4, 1'b0);
      expectAt(138, "release4_stage1", 1'b0, 3'b011, 1'b0, 1'b1, LIMIT ? 8'd0 : 8'd4, 1'b0);
      runTo(139);
      rst_n = 1'b0;
      #1;
      expectAt(cyc, "async_reset", 1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
      checkNow();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      expectAt(16, "post_reset_release", 1'b0, 3'b001, 1'b0, 1'b0, 8'd0, 1'b0);
      expectAt(21, "post_reset_run",     1'b0, 3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
      runTo(22);

      cmp("scoreboard", "pending", 8'(sb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
